// File: rtl/steer_input.sv
`default_nettype none
// ============================================================================
//  Module   : steer_input
//  Purpose  : Synchronises and debounces the left/right steering buttons and
//             turns them into tick-aligned, one-clock move pulses with an
//             immediate first step, a hold delay, then auto-repeat.
//  Options  : STEER_ACCEL_EN - when defined, the auto-repeat period halves
//             every ACCEL_STEPS repeat steps (floor 1) while a button is held.
//  Revision : 1.0 - initial release
// ============================================================================
module steer_input #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int ACCEL_STEPS     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       tick,
    output logic       left,
    output logic       right,
    output logic [1:0] held
);

    // Repeat counter must hold the larger of the two reload values.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_DEB_ONE  = CNT_W'(1);
    localparam logic [RPT_W-1:0] C_RD       = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] C_RP       = RPT_W'(REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] C_RPT_ONE  = RPT_W'(1);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_chk_deb
        $error("steer_input: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || ACCEL_STEPS < 1) begin : g_chk_rpt
        $error("steer_input: REPEAT_DELAY, REPEAT_PERIOD and ACCEL_STEPS must be >= 1");
    end

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // Bit 1 = left button, bit 0 = right button throughout.
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] held_w;
    dir_t       dir_w;

    state_t           state_q;
    dir_t             last_dir_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             left_q;
    logic             right_q;

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= {btn_left, btn_right};
            sync_q <= meta_q;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [CNT_W-1:0] cnt_q;
        logic             lvl_q;

        // Debounced level follows the synchronised level only after it has differed for DEBOUNCE_CYCLES consecutive clocks.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync_q[i] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == C_DEB_LAST) begin
                cnt_q <= '0;
                lvl_q <= sync_q[i];
            end else begin
                cnt_q <= cnt_q + C_DEB_ONE;
            end
        end

        assign held_w[i] = lvl_q;
    end

    // Exactly one pressed button gives a direction; none or both means stay put.
    always_comb begin
        dir_w = DIR_NONE;
        if (held_w == 2'b10) begin
            dir_w = DIR_LEFT;
        end else if (held_w == 2'b01) begin
            dir_w = DIR_RIGHT;
        end
    end

`ifdef STEER_ACCEL_EN
    localparam int               ACC_W      = $clog2(ACCEL_STEPS + 1);
    localparam logic [ACC_W-1:0] C_ACC_LAST = ACC_W'(ACCEL_STEPS - 1);
    localparam logic [ACC_W-1:0] C_ACC_ONE  = ACC_W'(1);

    logic [RPT_W-1:0] period_q;
    logic [ACC_W-1:0] acc_cnt_q;
    logic [RPT_W-1:0] period_half_w;

    assign period_half_w = (period_q > C_RPT_ONE) ? (period_q >> 1) : C_RPT_ONE;
`endif

    // Step scheduler: immediate step on press or reversal, one step after the hold delay, then periodic repeat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            last_dir_q <= DIR_NONE;
            rpt_cnt_q  <= '0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
`ifdef STEER_ACCEL_EN
            period_q   <= C_RP;
            acc_cnt_q  <= '0;
`endif
        end else begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            if (dir_w == DIR_NONE) begin
                state_q <= S_IDLE;
`ifdef STEER_ACCEL_EN
                period_q  <= C_RP;
                acc_cnt_q <= '0;
`endif
            end else if (tick) begin
                if (state_q == S_IDLE || dir_w != last_dir_q) begin
                    left_q     <= (dir_w == DIR_LEFT);
                    right_q    <= (dir_w == DIR_RIGHT);
                    last_dir_q <= dir_w;
                    rpt_cnt_q  <= C_RD;
                    state_q    <= S_DELAY;
`ifdef STEER_ACCEL_EN
                    period_q   <= C_RP;
                    acc_cnt_q  <= '0;
`endif
                end else if (rpt_cnt_q == C_RPT_ONE) begin
                    left_q  <= (last_dir_q == DIR_LEFT);
                    right_q <= (last_dir_q == DIR_RIGHT);
                    if (state_q == S_DELAY) begin
                        rpt_cnt_q <= C_RP;
                        state_q   <= S_REPEAT;
                    end else begin
`ifdef STEER_ACCEL_EN
                        // The step that completes a stage reloads with the already-halved period.
                        if (acc_cnt_q == C_ACC_LAST) begin
                            acc_cnt_q <= '0;
                            period_q  <= period_half_w;
                            rpt_cnt_q <= period_half_w;
                        end else begin
                            acc_cnt_q <= acc_cnt_q + C_ACC_ONE;
                            rpt_cnt_q <= period_q;
                        end
`else
                        rpt_cnt_q <= C_RP;
`endif
                    end
                end else begin
                    rpt_cnt_q <= rpt_cnt_q - C_RPT_ONE;
                end
            end
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign held  = held_w;

endmodule
`default_nettype wire

// File: tb/tb_steer_input.sv
`default_nettype none
// Bench for steer_input: a tick-schedule model compared every cycle, plus
// hand-computed pulse spacing and debounce latency checks.
module tb_steer_input;

    localparam int DEB = 4;
    localparam int RD  = 3;
    localparam int RP  = 2;
    localparam int AS  = 2;

`ifdef STEER_ACCEL_EN
    localparam int LATE_GAP = 5;
`else
    localparam int LATE_GAP = 10;
`endif

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       btn_left  = 1'b0;
    logic       btn_right = 1'b0;
    logic       tick      = 1'b0;
    logic       left;
    logic       right;
    logic [1:0] held;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int tphase      = 0;
    bit tick_hold   = 1'b0;
    int lp[$];
    int rp[$];

    always #5 clk = ~clk;

    steer_input #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (16),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .ACCEL_STEPS    (AS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .tick     (tick),
        .left     (left),
        .right    (right),
        .held     (held)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Game tick: one cycle in five, or every cycle while tick_hold is set.
    always @(negedge clk) begin
        tick   = tick_hold || (tphase == 0);
        tphase = (tphase == 4) ? 0 : tphase + 1;
    end

    // ---------------- behavioural model ----------------
    logic [1:0] m_held = 2'b00;
    logic       m_l = 1'b0;
    logic       m_r = 1'b0;
    bit         m_act = 1'b0;
    int         m_dir = 0;   // 0 none, 1 left, 2 right
    int         m_t = 0;
    int         m_next = 0;
    int         m_g = 0;
    bit         hl[$];
    bit         hr[$];

    // Gap in ticks after the g-th scheduled repeat interval.
    function automatic int gap(input int g);
`ifdef STEER_ACCEL_EN
        int p;
        p = RP >> (g / AS);
        return (p < 1) ? 1 : p;
`else
        return RP + 0 * g;
`endif
    endfunction

    // Oldest DEB entries of the history are the synchronised samples of the last DEB clocks.
    function automatic bit window_differs(input bit q[$], input logic v);
        bit d;
        d = 1'b1;
        for (int i = 0; i < DEB; i++) if (q[i] == v) d = 1'b0;
        return d;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_held = 2'b00;
            m_l    = 1'b0;
            m_r    = 1'b0;
            m_act  = 1'b0;
            hl.delete();
            hr.delete();
            for (int i = 0; i < DEB + 2; i++) begin
                hl.push_back(1'b0);
                hr.push_back(1'b0);
            end
        end else begin : model_step
            int d;
            d   = (m_held == 2'b10) ? 1 : (m_held == 2'b01) ? 2 : 0;
            m_l = 1'b0;
            m_r = 1'b0;
            if (d == 0) begin
                m_act = 1'b0;
            end else if (tick) begin
                if (!m_act || d != m_dir) begin
                    m_act  = 1'b1;
                    m_dir  = d;
                    m_t    = 0;
                    m_next = RD;
                    m_g    = 0;
                    m_l    = (d == 1);
                    m_r    = (d == 2);
                end else begin
                    m_t++;
                    if (m_t == m_next) begin
                        m_l    = (m_dir == 1);
                        m_r    = (m_dir == 2);
                        m_next = m_next + gap(m_g);
                        m_g++;
                    end
                end
            end
            hl.push_back(btn_left);
            hr.push_back(btn_right);
            void'(hl.pop_front());
            void'(hr.pop_front());
            if (window_differs(hl, m_held[1])) m_held[1] = ~m_held[1];
            if (window_differs(hr, m_held[0])) m_held[0] = ~m_held[0];
        end
    end

    // Every-cycle comparison against the model, plus pulse logging.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            chk("left", left, m_l);
            chk("right", right, m_r);
            chk("held", held, m_held);
            if (left === 1'b1) lp.push_back(cyc);
            if (right === 1'b1) rp.push_back(cyc);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic [1:0] v, output int at);
        at = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #3;
            if (held === v) begin
                at = cyc;
                break;
            end
        end
        chk("held_reached", (at >= 0), 1);
    endtask

    task automatic chk_gap(input string name, input int q[$], input int idx, input int exp);
        if (q.size() > idx) chk(name, q[idx] - q[idx-1], exp);
        else chk(name, q.size(), idx + 1);
    endtask

    initial begin : stim
        int at;
        // 1. buttons toggle during reset; nothing may come out
        clks(2);
        btn_left = 1'b1;
        clks(3);
        btn_right = 1'b1;
        clks(3);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        clks(2);
        @(posedge clk);
        #3;
        chk("rst_held", held, 2'b00);
        chk("rst_left", left, 1'b0);
        chk("rst_right", right, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        clks(8);
        chk("post_rst_pulses", lp.size() + rp.size(), 0);
        chk("post_rst_held", held, 2'b00);

        // 2. 3-clock glitch is rejected; a real press lands exactly 6 clocks later
        btn_left = 1'b1;
        clks(3);
        btn_left = 1'b0;
        clks(10);
        chk("glitch_held", held, 2'b00);
        chk("glitch_pulses", lp.size(), 0);
        btn_left = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        chk("lat_edge5", held, 2'b00);
        @(posedge clk);
        #3;
        chk("lat_edge6", held, 2'b10);
        at = cyc;
        lp.delete();

        // 3. steady left hold: tick gaps 3,2,2 then 2 (or 1 with acceleration)
        clks(54);
        chk("t3_first_lat_ok", (lp.size() > 0 && lp[0] - at >= 1 && lp[0] - at <= 5), 1);
        chk_gap("t3_gap1", lp, 1, 15);
        chk_gap("t3_gap2", lp, 2, 10);
        chk_gap("t3_gap3", lp, 3, 10);
        chk_gap("t3_gap4", lp, 4, LATE_GAP);
        chk("t3_no_right", rp.size(), 0);
        btn_left = 1'b0;
        clks(12);

        // 4. both held: no motion; dropping right resumes left with the delay schedule
        btn_left  = 1'b1;
        btn_right = 1'b1;
        wait_held(2'b11, at);
        lp.delete();
        rp.delete();
        clks(20);
        chk("t4_both_no_pulse", lp.size() + rp.size(), 0);
        btn_right = 1'b0;
        wait_held(2'b10, at);
        clks(40);
        chk("t4_first_lat_ok", (lp.size() > 0 && lp[0] - at >= 1 && lp[0] - at <= 5), 1);
        chk_gap("t4_gap1", lp, 1, 15);
        chk("t4_no_right", rp.size(), 0);
        btn_left = 1'b0;
        clks(12);

        // 5. right into repeat, then reverse to left
        btn_right = 1'b1;
        clks(40);
        chk("t5_right_moved", (rp.size() >= 3), 1);
        btn_right = 1'b0;
        btn_left  = 1'b1;
        wait_held(2'b10, at);
        lp.delete();
        rp.delete();
        clks(30);
        chk("t5_first_lat_ok", (lp.size() > 0 && lp[0] - at >= 1 && lp[0] - at <= 5), 1);
        chk_gap("t5_gap1", lp, 1, 15);
        chk("t5_no_right", rp.size(), 0);

        // tick held high for several cycles: each cycle is a tick
        tick_hold = 1'b1;
        clks(6);
        tick_hold = 1'b0;
        clks(10);

        // asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_held", held, 2'b00);
        chk("async_rst_left", left, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        clks(30);
        btn_left = 1'b0;
        clks(12);

        // 6. right hold repeat gaps, then release and press again
        btn_right = 1'b1;
        wait_held(2'b01, at);
        rp.delete();
        clks(70);
        chk_gap("t6_gap1", rp, 1, 15);
        chk_gap("t6_gap2", rp, 2, 10);
        chk_gap("t6_gap3", rp, 3, 10);
        chk_gap("t6_gap4", rp, 4, LATE_GAP);
        chk_gap("t6_gap5", rp, 5, LATE_GAP);
        btn_right = 1'b0;
        clks(12);
        btn_right = 1'b1;
        wait_held(2'b01, at);
        rp.delete();
        clks(35);
        chk_gap("t6_regap1", rp, 1, 15);
        chk_gap("t6_regap2", rp, 2, 10);
        btn_right = 1'b0;
        clks(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
